uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single `uart_tx` transmitter among several byte producers (board renderer, status/win messages, debug echo). Round-robin grants per byte, with packet locking so multi-byte messages are never interleaved. Drives `uart_tx`'s `tx_data_valid`/`tx_byte` and sequences on its `tx_active`/`tx_done`. Sits between the game logic and `uart_tx` in the top level.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `TIMEOUT_CLKS`, 12000: cycles allowed in WAIT for `tx_done`; used only with `UART_TX_ARB_TIMEOUT_EN`. One frame at `CLKS_PER_BIT`=868 is 8680.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  per-requester byte request; held until acked.
- `req_byte`  in  N_REQ*8  packed bytes; requester i uses `[8i+7:8i]`.
- `req_last`  in  N_REQ  1 = this byte ends the requester's packet.
- `req_ack`  out  N_REQ  one-cycle pulse: byte sent, next may be presented.
- `grant_id`  out  $clog2(N_REQ)  index of current owner; valid while `busy`.
- `busy`  out  1  high in every state except IDLE.
- `tx_data_valid`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_byte`  out  8  byte to `uart_tx`; held from START until next load.
- `tx_active`  in  1  from `uart_tx`.
- `tx_done`  in  1  one-cycle completion pulse from `uart_tx`.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, START, WAIT, ACK, HOLD.
- IDLE: if any `req` and `tx_active`=0: pick first requesting index at or after `rr_ptr` (wrapping); latch `req_byte` slice, `req_last`, index into `grant_id` -> START. `tx_active`=1 blocks leaving IDLE.
- START: `tx_data_valid`=1 for exactly this cycle -> WAIT.
- WAIT: on `tx_done` -> ACK.
- ACK: `req_ack[grant_id]`=1 this cycle only. If latched last=1: `rr_ptr` <= `grant_id`+1 mod N_REQ -> IDLE. Else -> HOLD.
- HOLD: other requests ignored. When `req[grant_id]`=1, latch byte/last -> START. No timeout in HOLD.
- Requester contract: `req`, byte, last stable from assertion until ack cycle; new values take effect the cycle after ack. Arbiter never samples `req` during ACK.
- Simultaneous requests: lowest index at or after `rr_ptr` wins; rest wait.
- `tx_done` outside WAIT: ignored.
- Reset (any time, including mid-frame): state IDLE, `rr_ptr`=0, `grant_id`=0, `tx_byte`=0, all other outputs 0. The in-flight `uart_tx` frame completes; the `tx_active` guard prevents overlap.

## Timing
- `req` seen at cycle c in IDLE -> `tx_data_valid` high at c+1 -> WAIT from c+2.
- `tx_done` at cycle d -> `req_ack` at d+1 -> next IDLE/HOLD decision at d+2; next `tx_data_valid` no earlier than d+3.
- All outputs registered.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined: counter cleared on entering WAIT, incremented each WAIT cycle. Reaching `TIMEOUT_CLKS` without `tx_done` -> IDLE with no ack; `timeout_err` <= 1 (cleared only by reset); packet lock released; `rr_ptr` <= `grant_id`+1. The requester keeps `req` and re-arbitrates.
- Not defined: counter absent, `timeout_err` tied 0, WAIT waits forever.

## Structure
- `uart_pkg`: `CLKS_PER_BIT`=868, `arb_state_t` enum, `byte_t` typedef.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs `req` and `rr_ptr`; outputs `any` and `idx`.

## Test plan
- Single byte: requester 0 sends 0x3F, last=1, looped back through `uart_tx` -> `uart_rx`. `uart_rx` receives 0x3F. `req_ack[0]` pulses once, 1 cycle after `tx_done`.
- Contention: all three request at once, bytes 0xA1/0xB2/0xC3, each last=1, `rr_ptr`=0. Receive order A1, B2, C3. Then re-request all -> order A1, B2, C3 again.
- Packet lock: req0 sends "X","O","\n" (0x58, 0x4F, 0x0A), last on 0x0A only; req1 asserts 0x21 during the first byte. Receive order 58, 4F, 0A, 21.
- Fairness: req0 and req1 assert continuously with last=1. Grants alternate 0,1,0,1 over 4 bytes.
- Reset mid-frame: assert `reset`=0 during WAIT. All outputs 0 next cycle. A fresh request issues `tx_data_valid` only after `tx_active` falls.
- Timeout (macro on, `TIMEOUT_CLKS`=100, `tx_done` suppressed): `timeout_err`=1 at cycle 100 of WAIT, state IDLE, no `req_ack`.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  localparam int CLKS_PER_BIT = 868;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ACK,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer request and uart_tx handshake bundle for the arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 3
);
  import uart_pkg::*;

  logic [N_REQ-1:0]   req;
  logic [N_REQ*8-1:0] req_byte;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ack;
  logic               tx_data_valid;
  byte_t              tx_byte;
  logic               tx_active;
  logic               tx_done;

  // master: producers plus uart_tx; slave: the arbiter itself
  modport master (
    output req, req_byte, req_last, tx_active, tx_done,
    input  req_ack, tx_data_valid, tx_byte
  );

  modport slave (
    input  req, req_byte, req_last, tx_active, tx_done,
    output req_ack, tx_data_valid, tx_byte
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin selector: first requester at or after rr_ptr
module rr_pick #(
  parameter  int N = 3,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  always_comb begin : scan
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    // Scan farthest-first so the candidate closest to rr_ptr is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        any = 1'b1;
        idx = W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter sharing one uart_tx among N_REQ byte producers
// Optional WAIT watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ        = 3,
  parameter  int TIMEOUT_CLKS = 12000,
  localparam int ID_W         = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    bus,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic                timeout_err
);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic            last_q;
  logic            pick_any;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W-1:0] next_ptr;
  logic            wait_expired;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside WAIT so every WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign wait_expired = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CLKS - 1));
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      grant_id          <= '0;
      last_q            <= 1'b0;
      busy              <= 1'b0;
      timeout_err       <= 1'b0;
      bus.tx_byte       <= '0;
      bus.tx_data_valid <= 1'b0;
      bus.req_ack       <= '0;
    end else begin
      bus.tx_data_valid <= 1'b0;
      bus.req_ack       <= '0;
      case (state)
        IDLE: begin
          // A frame left over from before a reset keeps tx_active high; never overlap it.
          if (pick_any && !bus.tx_active) begin
            grant_id          <= pick_idx;
            bus.tx_byte       <= bus.req_byte[8*pick_idx +: 8];
            last_q            <= bus.req_last[pick_idx];
            busy              <= 1'b1;
            bus.tx_data_valid <= 1'b1;
            state             <= START;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done) begin
            bus.req_ack[grant_id] <= 1'b1;
            state                 <= ACK;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        ACK: begin
          if (last_q) begin
            rr_ptr <= next_ptr;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          // Packet lock: only the current owner may continue.
          if (bus.req[grant_id]) begin
            bus.tx_byte       <= bus.req_byte[8*grant_id +: 8];
            last_q            <= bus.req_last[grant_id];
            bus.tx_data_valid <= 1'b1;
            state             <= START;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench: uart_tx model plus byte/grant scoreboard
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N_REQ = 3;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TIMEOUT_CLKS = 100;
`else
  localparam int TIMEOUT_CLKS = 12000;
`endif
  localparam int FRAME = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  logic [N_REQ-1:0]   req_r = '0;
  logic [N_REQ*8-1:0] byte_r = '0;
  logic [N_REQ-1:0]   last_r = '0;
  logic               tx_active_r = 1'b0;
  logic               tx_done_r = 1'b0;

  logic [8:0]  pend [N_REQ][$];
  logic [10:0] exp_q [$];
  int          acks_seen [N_REQ];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          suppress_done = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) ifc ();

  assign ifc.req       = req_r;
  assign ifc.req_byte  = byte_r;
  assign ifc.req_last  = last_r;
  assign ifc.tx_active = tx_active_r;
  assign ifc.tx_done   = tx_done_r;

  uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (ifc.slave),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Requesters: hold each byte until acked, present the next one in the ack cycle.
  initial begin : driver
    logic [8:0] x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_r = '0;
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          if (req_r[i] && ifc.req_ack[i]) begin
            req_r[i] = 1'b0;
            acks_seen[i]++;
          end
          if (!req_r[i] && pend[i].size() > 0) begin
            x = pend[i].pop_front();
            byte_r[8*i +: 8] = x[7:0];
            last_r[i] = x[8];
            req_r[i] = 1'b1;
          end
        end
      end
    end
  end

  // uart_tx model: captures on tx_data_valid, busy FRAME cycles, then pulses tx_done.
  initial begin : tx_model
    logic [10:0] e;
    bit overlap;
    forever begin
      @(posedge clk);
      #1;
      tx_done_r = 1'b0;
      if (ifc.tx_data_valid) begin
        if (!suppress_done) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_byte got id=%0d byte=%02h want none", grant_id, ifc.tx_byte);
          end else begin
            e = exp_q.pop_front();
            if ({1'b0, grant_id, ifc.tx_byte} !== e) begin
              n_errors++;
              $display("FAIL sent_byte got id=%0d byte=%02h want id=%0d byte=%02h",
                       grant_id, ifc.tx_byte, e[10:8], e[7:0]);
            end
          end
        end
        overlap = 1'b0;
        tx_active_r = 1'b1;
        repeat (FRAME - 1) begin
          @(posedge clk);
          #1;
          if (ifc.tx_data_valid) overlap = 1'b1;
        end
        n_checks++;
        if (overlap !== 1'b0) begin
          n_errors++;
          $display("FAIL frame_overlap got start_while_active=%0b want 0", overlap);
        end
        tx_active_r = 1'b0;
        tx_done_r = !suppress_done;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit all_idle();
    bit r;
    r = (exp_q.size() == 0) && (req_r == '0) && !busy && !tx_active_r;
    for (int i = 0; i < N_REQ; i++) if (pend[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (!all_idle() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 3000) begin
      n_errors++;
      $display("FAIL %s_drain got pending=%0d want 0", name, exp_q.size());
    end
  endtask

  task automatic wait_tdv(input string name);
    int cyc = 0;
    while (!ifc.tx_data_valid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 500) begin
      n_errors++;
      $display("FAIL %s_start got no tx_data_valid want pulse", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (grant_id !== 2'd0) begin n_errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    if (ifc.tx_data_valid !== 1'b0) begin n_errors++; $display("FAIL reset_tdv got %0b want 0", ifc.tx_data_valid); end
    if (ifc.tx_byte !== 8'h00) begin n_errors++; $display("FAIL reset_byte got %02h want 00", ifc.tx_byte); end
    if (ifc.req_ack !== 3'b000) begin n_errors++; $display("FAIL reset_ack got %b want 000", ifc.req_ack); end
    if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL reset_timeout got %0b want 0", timeout_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int a0 = acks_seen[0];
    int cyc = 0;
    exp_q.push_back({3'd0, 8'h3F});
    pend[0].push_back({1'b1, 8'h3F});
    while (!tx_done_r && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) begin n_errors++; $display("FAIL single_done got no tx_done want pulse"); end
    @(negedge clk);
    n_checks++;
    if (ifc.req_ack !== 3'b001) begin n_errors++; $display("FAIL single_ack got %b want 001", ifc.req_ack); end
    @(negedge clk);
    n_checks++;
    if (ifc.req_ack !== 3'b000) begin n_errors++; $display("FAIL single_ack_pulse got %b want 000", ifc.req_ack); end
    wait_drain("single");
    n_checks++;
    if (acks_seen[0] !== a0 + 1) begin
      n_errors++;
      $display("FAIL single_ack_count got %0d want %0d", acks_seen[0] - a0, 1);
    end
  endtask

  task automatic test_contention();
    logic [7:0] b [3];
    b[0] = 8'hA1; b[1] = 8'hB2; b[2] = 8'hC3;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N_REQ; i++) begin
        exp_q.push_back({3'(i), b[i]});
        pend[i].push_back({1'b1, b[i]});
      end
      wait_drain("contention");
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    exp_q.push_back({3'd0, 8'h58});
    exp_q.push_back({3'd0, 8'h4F});
    exp_q.push_back({3'd0, 8'h0A});
    exp_q.push_back({3'd1, 8'h21});
    pend[0].push_back({1'b0, 8'h58});
    pend[0].push_back({1'b0, 8'h4F});
    pend[0].push_back({1'b1, 8'h0A});
    wait_tdv("lock");
    pend[1].push_back({1'b1, 8'h21});
    wait_drain("lock");
  endtask

  // rr_ptr is 2 after the packet-lock test, so the scan wraps to requester 0 first.
  task automatic test_fairness();
    exp_q.push_back({3'd0, 8'h10});
    exp_q.push_back({3'd1, 8'h20});
    exp_q.push_back({3'd0, 8'h11});
    exp_q.push_back({3'd1, 8'h21});
    pend[0].push_back({1'b1, 8'h10});
    pend[0].push_back({1'b1, 8'h11});
    pend[1].push_back({1'b1, 8'h20});
    pend[1].push_back({1'b1, 8'h21});
    wait_drain("fairness");
  endtask

  task automatic test_reset_midframe();
    int cyc = 0;
    bit seen_idle = 1'b0;
    exp_q.push_back({3'd2, 8'h55});
    pend[2].push_back({1'b1, 8'h55});
    while (!(busy && tx_active_r && !ifc.tx_data_valid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) begin n_errors++; $display("FAIL midframe_wait got no WAIT want WAIT"); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks += 5;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
    if (grant_id !== 2'd0) begin n_errors++; $display("FAIL midreset_grant got %0d want 0", grant_id); end
    if (ifc.tx_data_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_tdv got %0b want 0", ifc.tx_data_valid); end
    if (ifc.tx_byte !== 8'h00) begin n_errors++; $display("FAIL midreset_byte got %02h want 00", ifc.tx_byte); end
    if (ifc.req_ack !== 3'b000) begin n_errors++; $display("FAIL midreset_ack got %b want 000", ifc.req_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({3'd1, 8'h66});
    pend[1].push_back({1'b1, 8'h66});
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ifc.tx_data_valid) break;
      if (!tx_active_r) seen_idle = 1'b1;
    end
    n_checks++;
    if (seen_idle !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_guard got start_before_idle=%0b want 0", !seen_idle);
    end
    wait_drain("midreset");
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int a0;
    int cyc = 0;
    do_reset();
    a0 = acks_seen[0];
    suppress_done = 1'b1;
    pend[0].push_back({1'b1, 8'h77});
    wait_tdv("timeout");
    while (!timeout_err && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    n_checks += 4;
    if (cyc !== TIMEOUT_CLKS + 1) begin n_errors++; $display("FAIL timeout_cycles got %0d want %0d", cyc, TIMEOUT_CLKS + 1); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL timeout_idle got busy=%0b want 0", busy); end
    if (acks_seen[0] !== a0) begin n_errors++; $display("FAIL timeout_noack got %0d want %0d", acks_seen[0], a0); end
    if (ifc.req_ack !== 3'b000) begin n_errors++; $display("FAIL timeout_ack got %b want 000", ifc.req_ack); end
    do_reset();
    suppress_done = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL timeout_clear got %0b want 0", timeout_err); end
    wait_drain("timeout");
  endtask
`else
  task automatic test_timeout();
    n_checks++;
    if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL timeout_tied got %0b want 0", timeout_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_packet_lock();
    test_fairness();
    test_reset_midframe();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
